switch_allocator: RTL and testbench

- Per-cycle controller for the 5x5 router crossbar.
- Decides, for each output port, which input buffer may forward its head flit. Uses wormhole locking from head flit to tail flit, round-robin fairness among competing heads, and downstream credit gating.
- Sits between the input buffers and credit counters on one side and the crossbar select and valid lines on the other. Drives the buffer pop strobes and the credit-decrement strobes.
- Port index everywhere: 4=North, 3=East, 2=West, 1=South, 0=Local.

---
 rtl/switch_allocator.sv | 213 +++++++++++++++++++++
 tb/tb_switch_allocator.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_allocator.sv
// switch_allocator: per-cycle output arbitration for a 5x5 wormhole router.
// Each output either follows the input that holds its wormhole lock, or runs
// a round-robin pick among competing head flits. Grants are gated by the
// downstream credit of that output. Grants are combinational from the
// registered lock/owner/pointer state and the current requests.
// Port index: 4=North, 3=East, 2=West, 1=South, 0=Local.
module switch_allocator #(
  parameter bit          LOCAL_UTURN = 1'b0,
  parameter int unsigned RR_INIT     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  req_valid_i,
  input  logic [24:0] req_dir_i,
  input  logic [4:0]  req_tail_i,
  input  logic [4:0]  credit_avail_i,
  output logic [4:0]  grant_o,
  output logic [4:0]  out_valid_o,
  output logic [14:0] sel_o,
  output logic [4:0]  lock_o,
  output logic        err_o
);

  localparam int         NP       = 5;
  localparam logic [2:0] PTR_RST  = 3'(RR_INIT);
  localparam logic [2:0] IDLE_SEL = 3'b111;

  // legal_vec[5*o+i]: input i legally requests output o this cycle
  logic [24:0] legal_vec;
  logic [4:0]  illegal_in;
  logic [4:0]  owner_busy;
  logic [4:0]  lock_vec;
  logic [4:0]  gnt_vec;
  logic [4:0]  misdir_vec;
  logic [14:0] owner_vec;
  logic [14:0] win_vec;
  logic        err_reg;
  logic        err_next;

  // Classify every valid head request as legal (one-hot, no U-turn) or illegal
  always_comb begin
    logic [4:0] dir;
    logic       one_hot;
    logic       uturn;
    legal_vec  = '0;
    illegal_in = '0;
    dir        = '0;
    one_hot    = 1'b0;
    uturn      = 1'b0;
    for (int i = 0; i < NP; i++) begin
      dir     = req_dir_i[5*i +: 5];
      one_hot = (dir != 5'd0) && ((dir & (dir - 5'd1)) == 5'd0);
      // Local-to-local is the only U-turn that can be allowed
      uturn   = dir[i] && !((i == 0) && LOCAL_UTURN);
      if (req_valid_i[i]) begin
        if (one_hot && !uturn) begin
          for (int o = 0; o < NP; o++) begin
            legal_vec[5*o + i] = dir[o];
          end
        end else begin
          illegal_in[i] = 1'b1;
        end
      end
    end
  end

  // Inputs that currently own a locked output may not compete for any other
  always_comb begin
    owner_busy = '0;
    for (int o = 0; o < NP; o++) begin
      for (int i = 0; i < NP; i++) begin
        if (lock_vec[o] && (owner_vec[3*o +: 3] == 3'(i))) begin
          owner_busy[i] = 1'b1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NP; gi++) begin : g_out
    logic       lock_reg;
    logic       lock_next;
    logic [2:0] owner_reg;
    logic [2:0] owner_next;
    logic [2:0] ptr_reg;
    logic [2:0] ptr_next;
    logic [4:0] reqs;
    logic       gnt;
    logic [2:0] win;
    logic       misdir;

    assign reqs = legal_vec[5*gi +: 5];

    // Pick this output's winner (lock owner or round-robin) and its next state
    always_comb begin
      logic [4:0] elig;
      logic       found;
      logic       win_tail;
      logic       owner_valid;
      logic       owner_dir;
      int         rot;
      gnt         = 1'b0;
      win         = 3'd0;
      misdir      = 1'b0;
      found       = 1'b0;
      win_tail    = 1'b0;
      owner_valid = 1'b0;
      owner_dir   = 1'b0;
      rot         = 0;
      lock_next   = lock_reg;
      owner_next  = owner_reg;
      ptr_next    = ptr_reg;
      elig        = reqs & ~owner_busy;
      if (lock_reg) begin
        win = owner_reg;
        for (int i = 0; i < NP; i++) begin
          if (owner_reg == 3'(i)) begin
            owner_valid = req_valid_i[i];
            owner_dir   = req_dir_i[5*i + gi];
            found       = reqs[i];
          end
        end
        // Owner mid-packet pointing elsewhere: refuse and flag it
        misdir = owner_valid && !owner_dir;
      end else begin
        for (int k = 0; k < NP; k++) begin
          rot = int'(ptr_reg) + k;
          if (rot >= NP) begin
            rot = rot - NP;
          end
          for (int i = 0; i < NP; i++) begin
            if (!found && (rot == i) && elig[i]) begin
              found = 1'b1;
              win   = 3'(i);
            end
          end
        end
      end
      for (int i = 0; i < NP; i++) begin
        if (win == 3'(i)) begin
          win_tail = req_tail_i[i];
        end
      end
      gnt = found && credit_avail_i[gi];
      if (gnt) begin
        if (lock_reg) begin
          if (win_tail) begin
            lock_next = 1'b0;
          end
        end else begin
          ptr_next = (win == 3'd4) ? 3'd0 : win + 3'd1;
          if (!win_tail) begin
            lock_next  = 1'b1;
            owner_next = win;
          end
        end
      end
    end

    // Per-output lock, owner and round-robin pointer registers
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        lock_reg  <= 1'b0;
        owner_reg <= 3'd0;
        ptr_reg   <= PTR_RST;
      end else begin
        lock_reg  <= lock_next;
        owner_reg <= owner_next;
        ptr_reg   <= ptr_next;
      end
    end

    assign lock_vec[gi]         = lock_reg;
    assign owner_vec[3*gi +: 3] = owner_reg;
    assign gnt_vec[gi]          = gnt;
    assign win_vec[3*gi +: 3]   = win;
    assign misdir_vec[gi]       = misdir;
  end

  assign err_next = err_reg | (|illegal_in) | (|misdir_vec);

  // Sticky protocol-error flag, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= err_next;
    end
  end

  // Crossbar select, output valid and input pop strobes; all idle during reset
  always_comb begin
    grant_o     = '0;
    out_valid_o = '0;
    sel_o       = {NP{IDLE_SEL}};
    if (rst) begin
      for (int o = 0; o < NP; o++) begin
        if (gnt_vec[o]) begin
          out_valid_o[o]   = 1'b1;
          sel_o[3*o +: 3]  = win_vec[3*o +: 3];
          for (int i = 0; i < NP; i++) begin
            if (win_vec[3*o +: 3] == 3'(i)) begin
              grant_o[i] = 1'b1;
            end
          end
        end
      end
    end
  end

  assign lock_o = lock_vec;
  assign err_o  = err_reg;

endmodule

// File: tb/tb_switch_allocator.sv
// tb_switch_allocator: directed scenarios plus randomized packet traffic,
// all cycles compared against a packet-level reference model.
module tb_switch_allocator;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  req_valid_i;
  logic [24:0] req_dir_i;
  logic [4:0]  req_tail_i;
  logic [4:0]  credit_avail_i;
  logic [4:0]  grant_o;
  logic [4:0]  out_valid_o;
  logic [14:0] sel_o;
  logic [4:0]  lock_o;
  logic        err_o;

  switch_allocator #(.LOCAL_UTURN(1'b0), .RR_INIT(0)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid_i),
    .req_dir_i      (req_dir_i),
    .req_tail_i     (req_tail_i),
    .credit_avail_i (credit_avail_i),
    .grant_o        (grant_o),
    .out_valid_o    (out_valid_o),
    .sel_o          (sel_o),
    .lock_o         (lock_o),
    .err_o          (err_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state
  int m_lock[5];
  int m_owner[5];
  int m_ptr[5];
  bit m_err;
  // Model expectations for the current cycle
  int          e_win[5];
  bit          e_err_set;
  logic [4:0]  e_grant;
  logic [4:0]  e_valid;
  logic [14:0] e_sel;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [24:0] dir1(input int i, input int o);
    logic [24:0] r;
    r = '0;
    r[5*i + o] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    for (int o = 0; o < 5; o++) begin
      m_lock[o] = 0; m_owner[o] = 0; m_ptr[o] = 0;
    end
    m_err = 1'b0;
  endtask

  // Derive this cycle's grants from packet-level rules
  task automatic model_eval();
    int to[5];
    bit busy[5];
    logic [4:0] d;
    int w;
    int c;
    e_grant = '0; e_valid = '0; e_sel = '1; e_err_set = 1'b0;
    for (int i = 0; i < 5; i++) begin
      to[i] = -1; busy[i] = 1'b0;
      if (req_valid_i[i]) begin
        d = req_dir_i[5*i +: 5];
        if ($countones(d) == 1) begin
          for (int o = 0; o < 5; o++) if (d[o]) to[i] = o;
          if (to[i] == i) begin to[i] = -1; e_err_set = 1'b1; end
        end else begin
          e_err_set = 1'b1;
        end
      end
    end
    for (int o = 0; o < 5; o++) if (m_lock[o] != 0) busy[m_owner[o]] = 1'b1;
    for (int o = 0; o < 5; o++) begin
      e_win[o] = -1;
      if (m_lock[o] != 0) begin
        w = m_owner[o];
        if (to[w] == o) begin
          if (credit_avail_i[o]) e_win[o] = w;
        end else if (req_valid_i[w]) begin
          e_err_set = 1'b1;
        end
      end else begin
        for (int k = 0; k < 5; k++) begin
          c = (m_ptr[o] + k) % 5;
          if (e_win[o] < 0 && to[c] == o && !busy[c]) e_win[o] = c;
        end
        if (!credit_avail_i[o]) e_win[o] = -1;
      end
      if (e_win[o] >= 0) begin
        e_valid[o] = 1'b1;
        e_grant[e_win[o]] = 1'b1;
        e_sel[3*o +: 3] = 3'(e_win[o]);
      end
    end
  endtask

  task automatic model_commit();
    int w;
    m_err = m_err | e_err_set;
    for (int o = 0; o < 5; o++) begin
      if (e_win[o] >= 0) begin
        w = e_win[o];
        if (m_lock[o] != 0) begin
          if (req_tail_i[w]) m_lock[o] = 0;
        end else begin
          m_ptr[o] = (w + 1) % 5;
          if (!req_tail_i[w]) begin m_lock[o] = 1; m_owner[o] = w; end
        end
      end
    end
  endtask

  task automatic drive(input logic [4:0] v, input logic [24:0] d, input logic [4:0] t, input logic [4:0] cr);
    req_valid_i = v; req_dir_i = d; req_tail_i = t; credit_avail_i = cr;
  endtask

  // Let combinational outputs settle, then compare against the model
  task automatic settle();
    logic [4:0] exp_lock;
    #2;
    model_eval();
    for (int o = 0; o < 5; o++) exp_lock[o] = (m_lock[o] != 0);
    $display("cyc=%0d valid=%b grant=%b outv=%b sel=%h lock=%b err=%b",
             cyc, req_valid_i, grant_o, out_valid_o, sel_o, lock_o, err_o);
    check_eq("m_grant", grant_o, e_grant);
    check_eq("m_outv", out_valid_o, e_valid);
    check_eq("m_sel", sel_o, e_sel);
    check_eq("m_lock", lock_o, exp_lock);
    check_eq("m_err", err_o, m_err);
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #2;
    check_eq("rst_grant", grant_o, 5'b0);
    check_eq("rst_outv", out_valid_o, 5'b0);
    check_eq("rst_sel", sel_o, 15'h7FFF);
    check_eq("rst_lock", lock_o, 5'b0);
    check_eq("rst_err", err_o, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  int          rem[5];
  int          dst[5];
  logic [4:0]  v;
  logic [4:0]  t;
  logic [4:0]  cr;
  logic [24:0] d;
  logic [4:0]  junk;

  initial begin
    // Reset with every input requesting and full credit
    drive(5'b11111, dir1(0,1) | dir1(1,2) | dir1(2,3) | dir1(3,4) | dir1(4,0), 5'b00000, 5'b11111);
    do_reset();

    // Contention for output 0: East then North, 3-flit packets
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(5'b11000, dir1(4,0) | dir1(3,0), (c == 2) ? 5'b01000 : 5'b00000, 5'b11111);
      settle();
      check_eq("cont_grant", grant_o, 5'b01000);
      check_eq("cont_sel", sel_o[2:0], 3'd3);
      if (c > 0) check_eq("cont_lock", lock_o[0], 1'b1);
      advance();
    end
    drive(5'b00000, '0, 5'b00000, 5'b11111);
    settle();
    check_eq("cont_gap_lock", lock_o[0], 1'b0);
    check_eq("cont_gap_grant", grant_o, 5'b0);
    advance();
    drive(5'b10000, dir1(4,0), 5'b00000, 5'b11111);
    settle();
    check_eq("cont_n_grant", grant_o, 5'b10000);
    check_eq("cont_n_sel", sel_o[2:0], 3'd4);
    advance();

    // Credit stall: South owns West, credit drops for 4 cycles
    do_reset();
    for (int c = 0; c < 8; c++) begin
      cr = (c >= 1 && c <= 4) ? 5'b11011 : 5'b11111;
      drive(5'b00010, dir1(1,2), (c == 7) ? 5'b00010 : 5'b00000, cr);
      settle();
      if (c >= 1 && c <= 4) begin
        check_eq("stall_grant", grant_o[1], 1'b0);
        check_eq("stall_outv", out_valid_o[2], 1'b0);
        check_eq("stall_lock", lock_o[2], 1'b1);
      end else begin
        check_eq("stall_go", grant_o[1], 1'b1);
      end
      advance();
    end
    drive(5'b00000, '0, 5'b00000, 5'b11111);
    settle();
    check_eq("stall_unlock", lock_o[2], 1'b0);
    advance();

    // Round-robin among single-flit streams to North
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(5'b00111, dir1(0,4) | dir1(1,4) | dir1(2,4), 5'b00111, 5'b11111);
      settle();
      check_eq("rr_grant", grant_o, 5'(1 << (c % 3)));
      check_eq("rr_lock", lock_o[4], 1'b0);
      advance();
    end

    // Protocol error: East U-turn
    do_reset();
    drive(5'b01000, dir1(3,3), 5'b01000, 5'b11111);
    settle();
    check_eq("err_grant", grant_o, 5'b0);
    check_eq("err_early", err_o, 1'b0);
    advance();
    drive(5'b00000, '0, 5'b00000, 5'b11111);
    for (int c = 0; c < 3; c++) begin
      settle();
      check_eq("err_sticky", err_o, 1'b1);
      advance();
    end

    // Reset mid-packet on output 1
    do_reset();
    drive(5'b00100, dir1(2,1), 5'b00000, 5'b11111);
    settle();
    check_eq("mid_head", grant_o, 5'b00100);
    advance();
    settle();
    check_eq("mid_locked", lock_o[1], 1'b1);
    rst = 1'b0;
    model_reset();
    #1;
    check_eq("mid_rst_lock", lock_o, 5'b0);
    check_eq("mid_rst_grant", grant_o, 5'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(5'b10000, dir1(4,1), 5'b10000, 5'b11111);
    settle();
    check_eq("mid_new_grant", grant_o, 5'b10000);
    check_eq("mid_new_sel", sel_o[5:3], 3'd4);
    advance();

    // Randomized packet traffic, illegal requests injected near the end
    do_reset();
    for (int i = 0; i < 5; i++) begin rem[i] = 0; dst[i] = 0; end
    for (int n = 0; n < 1500; n++) begin
      v = '0; t = '0; d = '0; cr = '0;
      for (int i = 0; i < 5; i++) begin
        if (rem[i] == 0 && ($urandom % 3) == 0) begin
          dst[i] = int'($urandom % 4);
          if (dst[i] >= i) dst[i] = dst[i] + 1;
          rem[i] = 1 + int'($urandom % 4);
        end
        if (rem[i] > 0) begin
          v[i] = (($urandom % 5) != 0);
          d[5*i + dst[i]] = 1'b1;
          t[i] = (rem[i] == 1);
        end else begin
          junk = 5'($urandom);
          d[5*i +: 5] = junk;
          if (n >= 1200 && ($urandom % 40) == 0) begin
            v[i] = 1'b1;
            d[5*i +: 5] = (($urandom % 2) == 0) ? 5'(1 << i) : 5'b00011;
          end
        end
        cr[i] = (($urandom % 5) != 0);
      end
      drive(v, d, t, cr);
      settle();
      for (int i = 0; i < 5; i++) if (e_grant[i] && rem[i] > 0) rem[i] = rem[i] - 1;
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
